// File: rtl/pipe_ctrl_chain.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_chain
//
// Purpose:
//   Control-word pipeline that carries decoded control words from the ID stage
//   through STAGES chained registers (stage 0 = EX ... stage STAGES-1 = WB).
//   Each stage has a valid bit. The chain supports a global stall (hold),
//   NOP insertion at stage 0 (bubble), a per-stage flush, and two wrap-around
//   counters: instructions retired into the last stage, and bubbles inserted.
//
//   A stage whose valid bit is 0 always holds exactly NOP_WORD. Downstream
//   logic can therefore use the stage word without gating it by valid.
//
// Ports:
//   clk_i            sole clock, rising edge
//   reset_i          synchronous, active-high reset
//   in_ctrl_i        [W]        decoded control word from ID
//   in_valid_i       [1]        in_ctrl_i is a real instruction
//   bubble_i         [1]        load a NOP into stage 0 this cycle
//   hold_i           [1]        global stall for all non-flushed stages
//   flush_mask_i     [STAGES]   bit i clears stage i on this edge
//   in_ready_o       [1]        ID may advance (combinational ~hold & ~bubble)
//   stage_ctrl_o     [STAGES*W] stage i word at bits [i*W +: W]
//   stage_valid_o    [STAGES]   per-stage valid bits
//   wb_rf_enable_o   [1]        last stage valid and its RF-enable bit set
//   retire_count_o   [CNT_W]    valid words that entered the last stage, wraps
//   bubble_count_o   [CNT_W]    bubbles inserted into stage 0, wraps
// -----------------------------------------------------------------------------
module pipe_ctrl_chain #(
    parameter int          W        = 16,
    parameter int          STAGES   = 3,
    parameter logic [W-1:0] NOP_WORD = {W{1'b0}},
    parameter int          RFE_BIT  = 0,
    parameter int          CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [W-1:0]          in_ctrl_i,
    input  logic                  in_valid_i,
    input  logic                  bubble_i,
    input  logic                  hold_i,
    input  logic [STAGES-1:0]     flush_mask_i,
    output logic                  in_ready_o,
    output logic [STAGES*W-1:0]   stage_ctrl_o,
    output logic [STAGES-1:0]     stage_valid_o,
    output logic                  wb_rf_enable_o,
    output logic [CNT_W-1:0]      retire_count_o,
    output logic [CNT_W-1:0]      bubble_count_o
);

    // Stage words packed so that stage i lands at bits [i*W +: W] when the
    // whole array is flattened onto stage_ctrl_o.
    logic [STAGES-1:0][W-1:0] word_q;
    logic [STAGES-1:0][W-1:0] word_d;
    logic [STAGES-1:0]        valid_q;
    logic [STAGES-1:0]        valid_d;
    logic [CNT_W-1:0]         retire_q;
    logic [CNT_W-1:0]         retire_d;
    logic [CNT_W-1:0]         bubble_q;
    logic [CNT_W-1:0]         bubble_d;

    // Event strobes for the counters.
    logic                     retire_inc_s;
    logic                     bubble_inc_s;

    // A valid word moves into the last stage only when the chain advances
    // and the last stage is not being flushed on the same edge.
    // A bubble is counted only when stage 0 actually advances into a NOP,
    // i.e. not during a stall and not when stage 0 is flushed anyway.
    // Counter strobes: derived from the current state and this cycle's controls.
    always_comb begin
        retire_inc_s = 1'b0;
        bubble_inc_s = 1'b0;
        if (!hold_i && !flush_mask_i[STAGES-1] && valid_q[STAGES-2]) begin
            retire_inc_s = 1'b1;
        end else begin
            retire_inc_s = 1'b0;
        end
        if (!hold_i && !flush_mask_i[0] && bubble_i) begin
            bubble_inc_s = 1'b1;
        end else begin
            bubble_inc_s = 1'b0;
        end
    end

    // Stage 0 next state: flush beats hold, hold beats advance. On advance a
    // bubble or an invalid input both load the NOP word with valid cleared.
    always_comb begin
        word_d[0]  = word_q[0];
        valid_d[0] = valid_q[0];
        if (flush_mask_i[0]) begin
            word_d[0]  = NOP_WORD;
            valid_d[0] = 1'b0;
        end else if (hold_i) begin
            word_d[0]  = word_q[0];
            valid_d[0] = valid_q[0];
        end else if (bubble_i || !in_valid_i) begin
            word_d[0]  = NOP_WORD;
            valid_d[0] = 1'b0;
        end else begin
            word_d[0]  = in_ctrl_i;
            valid_d[0] = 1'b1;
        end
    end

    // Stages 1..STAGES-1 next state: same priority, advancing copies the
    // upstream stage's word and valid bit unchanged.
    always_comb begin
        for (int i = 1; i < STAGES; i++) begin
            word_d[i]  = word_q[i];
            valid_d[i] = valid_q[i];
            if (flush_mask_i[i]) begin
                word_d[i]  = NOP_WORD;
                valid_d[i] = 1'b0;
            end else if (hold_i) begin
                word_d[i]  = word_q[i];
                valid_d[i] = valid_q[i];
            end else begin
                word_d[i]  = word_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Counter next state: plain modulo-2^CNT_W increment, no saturation.
    always_comb begin
        retire_d = retire_q;
        bubble_d = bubble_q;
        if (retire_inc_s) begin
            retire_d = retire_q + CNT_W'(1);
        end else begin
            retire_d = retire_q;
        end
        if (bubble_inc_s) begin
            bubble_d = bubble_q + CNT_W'(1);
        end else begin
            bubble_d = bubble_q;
        end
    end

    // State registers: reset overrides hold, flush and bubble on the same edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= NOP_WORD;
            end
            valid_q  <= {STAGES{1'b0}};
            retire_q <= {CNT_W{1'b0}};
            bubble_q <= {CNT_W{1'b0}};
        end else begin
            word_q   <= word_d;
            valid_q  <= valid_d;
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    // Outputs: everything comes straight from registers except in_ready_o,
    // which must react in the same cycle so ID does not advance into a stall
    // or bubble, and wb_rf_enable_o, which is a gate of registered bits only.
    assign in_ready_o     = ~hold_i & ~bubble_i;
    assign stage_ctrl_o   = word_q;
    assign stage_valid_o  = valid_q;
    assign wb_rf_enable_o = valid_q[STAGES-1] & word_q[STAGES-1][RFE_BIT];
    assign retire_count_o = retire_q;
    assign bubble_count_o = bubble_q;

endmodule
